// File: rtl/kick_requester.sv
// -----------------------------------------------------------------------------
// kick_requester
//
// Initiator side of the kicker command interface. Takes kick commands from the
// packet decoder, waits until the capacitor is charged (and, in auto-kick mode,
// until the ball is in the dribbler), then issues a one-cycle kickstart with a
// level-coded kicktime. Hold and cooldown windows are timed out locally so the
// kicker's latch and lockout windows are never violated.
//
// Sequence: IDLE -> ARMED -> FIRE -> HOLD -> COOLDOWN -> IDLE
//
// Ports
//   clk         in   1  system clock
//   rst         in   1  synchronous reset, active-high
//   cmd_valid   in   1  command present
//   cmd_ready   out  1  command accepted when cmd_valid & cmd_ready
//   cmd_power   in   4  0 = cancel, 1..11 = level, 12..15 clamp to 11
//   auto_kick   in   1  1 = fire only with ball present, 0 = fire when charged
//   done        in   1  charger "capacitor full" (asynchronous)
//   ball_sense  in   1  ball-in-dribbler sensor (asynchronous)
//   kickstart   out  1  one-cycle fire request
//   kicktime    out  8  level code, valid in FIRE and HOLD, otherwise 0
//   busy        out  1  high whenever not IDLE
//   timeout     out  1  one-cycle pulse when an armed command is abandoned
//   kick_count  out  8  kicks fired, wraps 255 -> 0
// -----------------------------------------------------------------------------
module kick_requester #(
  parameter int unsigned HOLD_CYC     = 4,
  parameter int unsigned COOLDOWN_CYC = 268435456,
  parameter int unsigned ARM_TIMEOUT  = 50000000,
  parameter int unsigned CNT_W        = 29
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_power,
  input  logic       auto_kick,
  input  logic       done,
  input  logic       ball_sense,
  output logic       kickstart,
  output logic [7:0] kicktime,
  output logic       busy,
  output logic       timeout,
  output logic [7:0] kick_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_FIRE,
    S_HOLD,
    S_COOL
  } state_t;

  // The shared down-counter is loaded with N-1 so a state lasts exactly N cycles.
  localparam logic [CNT_W-1:0] ARM_RELOAD  = CNT_W'(ARM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] COOL_RELOAD = CNT_W'(COOLDOWN_CYC - 1);

  function automatic logic [3:0] clamp_power(input logic [3:0] p);
    return (p > 4'd11) ? 4'd11 : p;
  endfunction

  function automatic logic [7:0] level_code(input logic [3:0] idx);
    logic [7:0] code;
    case (idx)
      4'd1:    code = 8'h01;
      4'd2:    code = 8'h03;
      4'd3:    code = 8'h07;
      4'd4:    code = 8'h1F;
      4'd5:    code = 8'h40;
      4'd6:    code = 8'h60;
      4'd7:    code = 8'h70;
      4'd8:    code = 8'h78;
      4'd9:    code = 8'h7C;
      4'd10:   code = 8'h7E;
      4'd11:   code = 8'h7F;
      default: code = 8'h00;
    endcase
    return code;
  endfunction

  // ---------------------------------------------------------------------------
  // Input synchronisers for the two asynchronous status lines
  // ---------------------------------------------------------------------------
  logic done_meta_q, done_s_q;
  logic ball_meta_q, ball_s_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the
  // two-stage synchroniser into one stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_meta_q <= 1'b0;
      done_s_q    <= 1'b0;
      ball_meta_q <= 1'b0;
      ball_s_q    <= 1'b0;
    end else begin
      done_meta_q <= done;
      done_s_q    <= done_meta_q;
      ball_meta_q <= ball_sense;
      ball_s_q    <= ball_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       idx_q;
  logic             cmd_ready_q;
  logic             kickstart_q;
  logic [7:0]       kicktime_q;
  logic             busy_q;
  logic             timeout_q;
  logic [7:0]       kick_count_q;

  logic             cmd_accept;
  logic             fire_cond;
  logic [3:0]       idx_d;
  logic [7:0]       kick_count_d;

  assign cmd_accept   = cmd_valid & cmd_ready_q;
  assign fire_cond    = done_s_q & (ball_s_q | ~auto_kick);
  assign idx_d        = clamp_power(cmd_power);
  assign kick_count_d = kick_count_q + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      cmd_ready_q  <= 1'b0;
      kickstart_q  <= 1'b0;
      kicktime_q   <= 8'h00;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
      kick_count_q <= 8'h00;
    end else begin
      // NOTE: pulse outputs default low every cycle and are raised only on the
      // transition that owns them, which keeps them to exactly one cycle.
      kickstart_q <= 1'b0;
      timeout_q   <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          // Also covers the first cycle out of reset, when ready is still low.
          cmd_ready_q <= 1'b1;
          if (cmd_accept && (cmd_power != 4'd0)) begin
            idx_q   <= idx_d;
            cnt_q   <= ARM_RELOAD;
            busy_q  <= 1'b1;
            state_q <= S_ARMED;
          end
        end

        S_ARMED: begin
          // An accepted command takes precedence and blocks firing this cycle.
          if (cmd_accept) begin
            if (cmd_power == 4'd0) begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              idx_q <= idx_d;
              cnt_q <= ARM_RELOAD;
            end
          end else if (fire_cond) begin
            kickstart_q  <= 1'b1;
            kicktime_q   <= level_code(idx_q);
            kick_count_q <= kick_count_d;
            cmd_ready_q  <= 1'b0;
            state_q      <= S_FIRE;
          end else if (cnt_q == '0) begin
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        S_FIRE: begin
          cnt_q   <= HOLD_RELOAD;
          state_q <= S_HOLD;
        end

        S_HOLD: begin
          if (cnt_q == '0) begin
            kicktime_q <= 8'h00;
            cnt_q      <= COOL_RELOAD;
            state_q    <= S_COOL;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        S_COOL: begin
          if (cnt_q == '0) begin
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        default: begin
          busy_q      <= 1'b0;
          cmd_ready_q <= 1'b0;
          kicktime_q  <= 8'h00;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign kickstart  = kickstart_q;
  assign kicktime   = kicktime_q;
  assign busy       = busy_q;
  assign timeout    = timeout_q;
  assign kick_count = kick_count_q;

endmodule

// File: tb/tb_kick_requester.sv
// -----------------------------------------------------------------------------
// tb_kick_requester
//
// Self-checking bench for kick_requester with short timing parameters. A
// timestamp-based reference model (edge numbers of arming, firing, timeout)
// predicts every output; a compare process checks all outputs on each falling
// edge. Directed sequences add hand-computed expectations, then a randomized
// phase exercises cancels, re-arms, timeouts and occasional resets.
// -----------------------------------------------------------------------------
module tb_kick_requester;

  localparam int HOLD = 4;
  localparam int COOL = 20;
  localparam int ARMT = 50;

  localparam logic [7:0] LEVEL [0:11] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h1F, 8'h40,
                                         8'h60, 8'h70, 8'h78, 8'h7C, 8'h7E, 8'h7F};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_power = 4'd0;
  logic       auto_kick = 1'b0;
  logic       done = 1'b0;
  logic       ball_sense = 1'b0;
  logic       kickstart;
  logic [7:0] kicktime;
  logic       busy;
  logic       timeout;
  logic [7:0] kick_count;

  kick_requester #(
    .HOLD_CYC    (HOLD),
    .COOLDOWN_CYC(COOL),
    .ARM_TIMEOUT (ARMT),
    .CNT_W       (29)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_power (cmd_power),
    .auto_kick (auto_kick),
    .done      (done),
    .ball_sense(ball_sense),
    .kickstart (kickstart),
    .kicktime  (kicktime),
    .busy      (busy),
    .timeout   (timeout),
    .kick_count(kick_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: tracks edge numbers of key events rather than states.
  // After edge n the requester is "kicking" while 0 <= n - fire_edge <= HOLD+COOL.
  // ---------------------------------------------------------------------------
  int   edge_n    = 0;
  bit   m_live    = 0;
  bit   m_armed   = 0;
  bit   m_ready   = 0;
  int   m_idx     = 0;
  int   m_deadline = 0;
  int   m_fire    = -100000;
  int   m_tmo     = -1;
  int   m_count   = 0;
  logic [7:0] m_code = 8'h00;
  bit   m_meta_d = 0, m_s_d = 0, m_meta_b = 0, m_s_b = 0;
  bit   m_acc;
  int   m_delta;

  always @(posedge clk) begin
    edge_n++;
    if (rst) begin
      m_live   = 1;
      m_armed  = 0;
      m_ready  = 0;
      m_idx    = 0;
      m_fire   = -100000;
      m_tmo    = -1;
      m_count  = 0;
      m_code   = 8'h00;
      m_meta_d = 0; m_s_d = 0; m_meta_b = 0; m_s_b = 0;
    end else begin
      m_acc = cmd_valid && m_ready;
      if (m_acc) begin
        if (cmd_power == 4'd0) begin
          m_armed = 0;
        end else begin
          m_armed    = 1;
          m_idx      = (cmd_power > 4'd11) ? 11 : int'(cmd_power);
          m_deadline = edge_n + ARMT;
        end
      end else if (m_armed && m_s_d && (m_s_b || !auto_kick)) begin
        m_armed = 0;
        m_fire  = edge_n;
        m_code  = LEVEL[m_idx];
        m_count = (m_count + 1) % 256;
      end else if (m_armed && edge_n == m_deadline) begin
        m_armed = 0;
        m_tmo   = edge_n;
      end
      m_s_d = m_meta_d; m_meta_d = done;
      m_s_b = m_meta_b; m_meta_b = ball_sense;
      m_delta = edge_n - m_fire;
      m_ready = !(m_delta >= 0 && m_delta <= HOLD + COOL);
    end
  end

  // Compare process: every output against the model on every falling edge.
  always @(negedge clk) begin
    if (m_live) begin
      m_delta = edge_n - m_fire;
      check("cmp_kickstart", 32'(kickstart), 32'(m_fire == edge_n));
      check("cmp_kicktime", 32'(kicktime),
            (m_delta >= 0 && m_delta <= HOLD) ? 32'(m_code) : 32'h0);
      check("cmp_busy", 32'(busy),
            32'(m_armed || (m_delta >= 0 && m_delta <= HOLD + COOL)));
      check("cmp_cmd_ready", 32'(cmd_ready), 32'(m_ready));
      check("cmp_timeout", 32'(timeout), 32'(m_tmo == edge_n));
      check("cmp_kick_count", 32'(kick_count), 32'(m_count));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic send_cmd(input logic [3:0] p);
    cmd_valid = 1'b1;
    cmd_power = p;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(output int ks);
    int k;
    k  = 0;
    ks = 0;
    while (busy && k < 200) begin
      if (kickstart) ks++;
      @(negedge clk);
      k++;
    end
    check("wait_idle_bound", 32'(busy), 32'h0);
  endtask

  task automatic wait_kick();
    int k;
    k = 0;
    while (!kickstart && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("wait_kick_bound", 32'(kickstart), 32'h1);
  endtask

  initial begin
    int ks, k, busy_cnt, kt_cnt, total;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_kick_count", 32'(kick_count), 32'h0);
    check("rst_kicktime", 32'(kicktime), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(cmd_ready), 32'h1);

    // 1. Charged, manual mode, power 4
    done = 1'b1;
    repeat (3) @(negedge clk);
    send_cmd(4'd4);
    busy_cnt = 0; kt_cnt = 0; ks = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) busy_cnt++;
      if (kickstart) ks++;
      if (kicktime == 8'h1F) kt_cnt++;
      @(negedge clk);
    end
    check("t1_kickstarts", 32'(ks), 32'd1);
    check("t1_kicktime_cycles", 32'(kt_cnt), 32'd5);
    check("t1_busy_cycles", 32'(busy_cnt), 32'd26);
    check("t1_kick_count", 32'(kick_count), 32'd1);

    // 2. Auto-kick waits for the ball
    auto_kick = 1'b1;
    send_cmd(4'd11);
    ks = 0;
    for (int i = 0; i < 10; i++) begin
      if (kickstart) ks++;
      @(negedge clk);
    end
    check("t2_no_ball_kick", 32'(ks), 32'd0);
    ball_sense = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!kickstart && k < 10);
    check("t2_ball_latency", 32'(k), 32'd3);
    check("t2_kicktime", 32'(kicktime), 32'h7F);
    wait_idle(ks);
    ball_sense = 1'b0;
    auto_kick  = 1'b0;

    // 3. Not charged -> timeout after ARMT armed cycles
    done = 1'b0;
    repeat (3) @(negedge clk);
    send_cmd(4'd1);
    k = 1; ks = 0;
    while (!timeout && k < 100) begin
      if (kickstart) ks++;
      @(negedge clk);
      k++;
    end
    check("t3_timeout_cycle", 32'(k), 32'd51);
    check("t3_timeout_busy", 32'(busy), 32'h0);
    check("t3_no_kick", 32'(ks), 32'd0);

    // 4. Cancel while armed, then clamped power
    send_cmd(4'd5);
    repeat (3) @(negedge clk);
    check("t4_armed_busy", 32'(busy), 32'h1);
    send_cmd(4'd0);
    check("t4_cancel_idle", 32'(busy), 32'h0);
    done = 1'b1;
    repeat (3) @(negedge clk);
    send_cmd(4'd15);
    wait_kick();
    check("t4_clamp_kicktime", 32'(kicktime), 32'h7F);
    wait_idle(ks);

    // 5a. Command held through cooldown is accepted on IDLE entry
    send_cmd(4'd3);
    done = 1'b0;
    repeat (8) @(negedge clk);
    cmd_valid = 1'b1;
    cmd_power = 4'd2;
    k = 0;
    while (!cmd_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("t5_ready_delay", 32'(k), 32'd18);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("t5_accepted_armed", 32'(busy), 32'h1);
    send_cmd(4'd0);

    // 5b. Reset during HOLD
    done = 1'b1;
    repeat (3) @(negedge clk);
    send_cmd(4'd6);
    wait_kick();
    @(negedge clk);
    check("t5_hold_kicktime", 32'(kicktime), 32'h60);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_kicktime", 32'(kicktime), 32'h0);
    check("t5_rst_busy", 32'(busy), 32'h0);
    check("t5_rst_count", 32'(kick_count), 32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 6. 256 kicks wrap the counter
    total = 0;
    for (int i = 0; i < 256; i++) begin
      send_cmd(4'($urandom_range(1, 15)));
      wait_idle(ks);
      total += ks;
    end
    check("t6_pulses", 32'(total), 32'd256);
    check("t6_wrap", 32'(kick_count), 32'd0);

    // Randomized phase
    for (int seg = 0; seg < 8; seg++) begin
      for (int i = 0; i < 500; i++) begin
        cmd_valid = (seg % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 63) == 0);
        cmd_power = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 29) == 0) done = ~done;
        if ($urandom_range(0, 7) == 0) ball_sense = ~ball_sense;
        if ($urandom_range(0, 31) == 0) auto_kick = ~auto_kick;
        rst = ($urandom_range(0, 599) == 0);
        @(negedge clk);
      end
    end
    rst = 1'b0;
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
